// File: rtl/usb_rx_pkt_pkg.sv
// Shared types and constants for the USB packet receiver.
// Error classes, FSM states, PID codes and CRC polynomials/residues.
package usb_rx_pkt_pkg;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_SYNC, ERR_STUFF, ERR_PID, ERR_CRC, ERR_ALIGN, ERR_LEN
  } rx_err_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_WAIT_EOP
  } rx_state_t;

  typedef enum logic [3:0] {
    PID_RSVD = 4'h0, PID_OUT   = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
    PID_PING = 4'h4, PID_SOF   = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
    PID_SPLT = 4'h8, PID_IN    = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
    PID_PRE  = 4'hC, PID_SETUP = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
  } pid_t;

  typedef enum logic { D_K = 1'b0, D_J = 1'b1 } d_port_t;

  // PID[1:0] classes select which CRC residue applies at end of packet
  localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/usb_rx_pkt_crc.sv
// Serial CRC register: feeds one bit per enable, MSB-first feedback.
// A received packet including its inverted CRC leaves a fixed residue.
module usb_crc #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_crc
);

  logic w_fb;

  assign w_fb = o_crc[WIDTH-1] ^ i_bit;

  always_ff @(posedge clk) begin
    if (!reset_n || i_init) begin
      o_crc <= '1;
    end else if (i_en) begin
      o_crc <= {o_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_rx_pkt.sv
// USB packet receiver: NRZI decode, SYNC detect, bit unstuffing, PID check,
// byte assembly and CRC5/CRC16 validation with a classified error per packet.
module usb_rx_pkt
  import usb_rx_pkt_pkg::*;
#(
  parameter int SYNC_LEN  = 8,
  parameter int MAX_BYTES = 1026,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clk_en,
  input  logic                               d_i,
  input  logic                               eop,
  output logic [7:0]                         data,
  output logic                               valid,
  output logic [3:0]                         pid,
  output logic                               pid_valid,
  output logic                               active,
  output logic                               done,
  output logic                               error,
  output rx_err_t                            err_code,
  output logic [$clog2(MAX_BYTES+2)-1:0]     byte_cnt,
  output rx_state_t                          o_dbg_state
);

  localparam int CNT_W = $clog2(MAX_BYTES+2);
  localparam int SC_W  = $clog2(SYNC_LEN);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES);
  localparam logic [SC_W-1:0]  SYNC_ZEROS = SC_W'(SYNC_LEN-2);

  rx_state_t         r_state, w_state;
  d_port_t           r_prev, w_prev;
  logic [SC_W-1:0]   r_sync_cnt, w_sync_cnt;
  logic [2:0]        r_ones, w_ones;
  logic [2:0]        r_bit_cnt, w_bit_cnt;
  logic [6:0]        r_sr, w_sr;
  logic [7:0]        w_data, w_byte;
  logic [3:0]        w_pid;
  logic              w_valid, w_pid_valid, w_active, w_done, w_error;
  rx_err_t           w_err_code, w_fail_code;
  logic [CNT_W-1:0]  w_byte_cnt, w_cnt_inc;
  logic              w_bit, w_fail, w_crc_init, w_crc_en, w_crc_ok;
  logic [4:0]        w_crc5;
  logic [15:0]       w_crc16;

  usb_crc #(.WIDTH(5), .POLY(CRC5_POLY)) u_crc5 (
    .clk(clk), .reset_n(reset_n), .i_init(w_crc_init), .i_en(w_crc_en),
    .i_bit(w_bit), .o_crc(w_crc5)
  );

  usb_crc #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk(clk), .reset_n(reset_n), .i_init(w_crc_init), .i_en(w_crc_en),
    .i_bit(w_bit), .o_crc(w_crc16)
  );

  assign w_bit       = (d_i == r_prev);
  assign w_byte      = {w_bit, r_sr};
  assign w_cnt_inc   = byte_cnt + 1'b1;
  assign o_dbg_state = r_state;

  always_comb begin
    w_crc_ok = 1'b1;
    if (CHECK_CRC) begin
      case (pid[1:0])
        PID_TYPE_TOKEN: w_crc_ok = (w_crc5 == CRC5_RESIDUE);
        PID_TYPE_DATA:  w_crc_ok = (w_crc16 == CRC16_RESIDUE);
        default:        w_crc_ok = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state     = r_state;
    w_prev      = r_prev;
    w_sync_cnt  = r_sync_cnt;
    w_ones      = r_ones;
    w_bit_cnt   = r_bit_cnt;
    w_sr        = r_sr;
    w_data      = data;
    w_valid     = 1'b0;
    w_pid       = pid;
    w_pid_valid = 1'b0;
    w_active    = active;
    w_done      = 1'b0;
    w_error     = 1'b0;
    w_err_code  = err_code;
    w_byte_cnt  = byte_cnt;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    w_crc_init  = 1'b0;
    w_crc_en    = 1'b0;
    if (eop) begin
      // eop beats a coincident bit strobe; the line returns to J idle
      w_prev   = D_J;
      w_state  = ST_IDLE;
      w_active = 1'b0;
      case (r_state)
        ST_SYNC: begin w_fail = 1'b1; w_fail_code = ERR_SYNC; end
        ST_PID:  begin w_fail = 1'b1; w_fail_code = ERR_PID;  end
        ST_DATA: begin
          if (r_bit_cnt != 3'd0) begin
            w_fail = 1'b1; w_fail_code = ERR_ALIGN;
          end else if (pid[1:0] == PID_TYPE_HANDSHAKE && byte_cnt != '0) begin
            w_fail = 1'b1; w_fail_code = ERR_LEN;
          end else if (!w_crc_ok) begin
            w_fail = 1'b1; w_fail_code = ERR_CRC;
          end else begin
            w_done = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (clk_en) begin
      w_prev = d_port_t'(d_i);
      case (r_state)
        ST_IDLE: begin
          if (!w_bit) begin
            w_state    = ST_SYNC;
            w_sync_cnt = '0;
            w_byte_cnt = '0;
            w_err_code = ERR_NONE;
          end
        end
        ST_SYNC: begin
          if (w_bit && r_sync_cnt == SYNC_ZEROS) begin
            w_state   = ST_PID;
            w_active  = 1'b1;
            w_ones    = 3'd1;
            w_bit_cnt = 3'd0;
          end else if (w_bit || r_sync_cnt == SYNC_ZEROS) begin
            w_fail = 1'b1; w_fail_code = ERR_SYNC;
          end else begin
            w_sync_cnt = r_sync_cnt + 1'b1;
          end
        end
        ST_PID, ST_DATA: begin
          if (r_ones == 3'd6) begin
            // stuffed bit: must be 0 and is dropped without touching the byte
            if (w_bit) begin
              w_fail = 1'b1; w_fail_code = ERR_STUFF;
            end else begin
              w_ones = 3'd0;
            end
          end else begin
            w_ones    = w_bit ? r_ones + 1'b1 : 3'd0;
            w_sr      = w_byte[7:1];
            w_bit_cnt = r_bit_cnt + 1'b1;
            if (r_state == ST_PID) begin
              if (r_bit_cnt == 3'd7) begin
                if (w_byte[3:0] == ~w_byte[7:4]) begin
                  w_pid       = w_byte[3:0];
                  w_pid_valid = 1'b1;
                  w_state     = ST_DATA;
                  w_crc_init  = 1'b1;
                end else begin
                  w_fail = 1'b1; w_fail_code = ERR_PID;
                end
              end
            end else begin
              w_crc_en = 1'b1;
              if (r_bit_cnt == 3'd7) begin
                w_byte_cnt = w_cnt_inc;
                if (w_cnt_inc > MAX_CNT) begin
                  w_fail = 1'b1; w_fail_code = ERR_LEN;
                end else begin
                  w_data  = w_byte;
                  w_valid = 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
    if (w_fail) begin
      w_error    = 1'b1;
      w_err_code = w_fail_code;
      w_active   = 1'b0;
      if (!eop) w_state = ST_WAIT_EOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_prev     <= D_J;
      r_sync_cnt <= '0;
      r_ones     <= '0;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
      data       <= '0;
      valid      <= 1'b0;
      pid        <= '0;
      pid_valid  <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      byte_cnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_prev     <= w_prev;
      r_sync_cnt <= w_sync_cnt;
      r_ones     <= w_ones;
      r_bit_cnt  <= w_bit_cnt;
      r_sr       <= w_sr;
      data       <= w_data;
      valid      <= w_valid;
      pid        <= w_pid;
      pid_valid  <= w_pid_valid;
      active     <= w_active;
      done       <= w_done;
      error      <= w_error;
      err_code   <= w_err_code;
      byte_cnt   <= w_byte_cnt;
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt.sv
// Directed bench for usb_rx_pkt: NRZI/stuffing line driver with random bit
// spacing, pulse monitor, expected-byte queue and immediate-assertion checks.
module tb_usb_rx_pkt;
  import usb_rx_pkt_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0, d_i = 1'b1, eop = 1'b0;
  logic [7:0]  data;
  logic        valid, pid_valid, active, done, error;
  logic [3:0]  pid;
  rx_err_t     err_code;
  logic [10:0] byte_cnt;
  rx_state_t   dbg_state;

  always #5 clk = ~clk;

  usb_rx_pkt dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .d_i(d_i), .eop(eop),
    .data(data), .valid(valid), .pid(pid), .pid_valid(pid_valid),
    .active(active), .done(done), .error(error), .err_code(err_code),
    .byte_cnt(byte_cnt), .o_dbg_state(dbg_state)
  );

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_pidv = 0, n_done = 0, n_err = 0;
  int b_valid, b_pidv, b_done, b_err, b_rx;
  logic [7:0] rx_q[$], tx_q[$], exp_q[$];
  logic tb_level = 1'b1, bad_stuff = 1'b0;
  int   tb_ones = 0, gap_max = 2;

  // pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (valid) begin n_valid++; rx_q.push_back(data); end
    if (pid_valid) n_pidv++;
    if (done) n_done++;
    if (error) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_pidv = n_pidv; b_done = n_done; b_err = n_err; b_rx = rx_q.size();
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic line_bit(input logic lvl);
    d_i = lvl; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
  endtask

  task automatic enc(input logic b);
    if (!b) tb_level = ~tb_level;
    line_bit(tb_level);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) enc(1'b0);
    enc(1'b1);
    tb_ones = 1;
  endtask

  task automatic send_dbit(input logic b);
    enc(b);
    tb_ones = b ? tb_ones + 1 : 0;
    if (tb_ones == 6) begin
      enc(bad_stuff);
      bad_stuff = 1'b0;
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++) send_dbit(x[i]);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0; d_i = 1'b1; tb_level = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_pkt(input int extra_bits);
    send_sync();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    for (int i = 0; i < extra_bits; i++) send_dbit(1'b0);
    send_eop();
  endtask

  // appends the inverted CRC16 of tx_q[1..] as two bytes, MSB first on the wire
  task automatic append_crc16();
    logic [15:0] c;
    logic [7:0]  b0, b1;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 1; i < tx_q.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ tx_q[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    c = ~c;
    for (int b = 0; b < 8; b++) begin b0[b] = c[15-b]; b1[b] = c[7-b]; end
    tx_q.push_back(b0);
    tx_q.push_back(b1);
  endtask

  task automatic check_bytes(input string tag);
    exp_q = tx_q[1:$];
    check(tag, rx_q.size() - b_rx, exp_q.size());
    foreach (exp_q[i])
      if (b_rx + i < rx_q.size()) check(tag, rx_q[b_rx+i], exp_q[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_pid_valid", pid_valid, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, ERR_NONE);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_data", data, 0);
    check("rst_pid", pid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SETUP token, addr 0 endp 0
    tx_q = '{8'h2D, 8'h00, 8'h10};
    snap(); send_pkt(0);
    check("setup_pidv", n_pidv - b_pidv, 1);
    check("setup_pid", pid, 4'hD);
    check_bytes("setup_data");
    check("setup_done", n_done - b_done, 1);
    check("setup_err", n_err - b_err, 0);
    check("setup_cnt", byte_cnt, 2);
    check("setup_code", err_code, ERR_NONE);
    check("setup_active", active, 0);

    // DATA0 00..07 with correct CRC16, then with a CRC bit flipped
    tx_q = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    append_crc16();
    snap(); send_pkt(0);
    check_bytes("data0_bytes");
    check("data0_done", n_done - b_done, 1);
    check("data0_cnt", byte_cnt, 10);
    tx_q[10] = tx_q[10] ^ 8'h01;
    snap(); send_pkt(0);
    check("crc_err_pulse", n_err - b_err, 1);
    check("crc_no_done", n_done - b_done, 0);
    check("crc_code", err_code, ERR_CRC);
    check("crc_valids", n_valid - b_valid, 10);

    // ACK with pid_valid latency probe
    snap();
    gap_max = 0;
    send_sync();
    send_byte(8'hD2);
    check("ack_pidv_latency", pid_valid, 1);
    check("ack_active", active, 1);
    gap_max = 2;
    send_eop();
    check("ack_pid", pid, 4'h2);
    check("ack_done", n_done - b_done, 1);
    check("ack_cnt", byte_cnt, 0);

    tx_q = '{8'hD2, 8'h00};
    snap(); send_pkt(0);
    check("hs_len_code", err_code, ERR_LEN);
    check("hs_len_err", n_err - b_err, 1);

    tx_q = '{8'h55};
    snap(); send_pkt(0);
    check("pid_bad_code", err_code, ERR_PID);
    check("pid_bad_pidv", n_pidv - b_pidv, 0);

    // DATA1 with runs of ones that force stuffing
    tx_q = '{8'h4B, 8'hFF, 8'hFF, 8'h12};
    append_crc16();
    snap(); send_pkt(0);
    check_bytes("stuff_bytes");
    check("stuff_done", n_done - b_done, 1);

    // stuffed bit forced to 1
    snap();
    send_sync();
    send_byte(8'h4B);
    bad_stuff = 1'b1;
    send_byte(8'hFF);
    settle();
    check("badstuff_err", n_err - b_err, 1);
    check("badstuff_code", err_code, ERR_STUFF);
    check("badstuff_active", active, 0);
    send_byte(8'hAA);
    send_eop();
    check("badstuff_valids", n_valid - b_valid, 0);
    check("badstuff_done", n_done - b_done, 0);
    tx_q = '{8'hD2};
    snap(); send_pkt(0);
    check("recover_done", n_done - b_done, 1);
    check("recover_pid", pid, 4'h2);

    // eop 3 bits past a byte boundary
    tx_q = '{8'h2D, 8'h00};
    snap(); send_pkt(3);
    check("align_code", err_code, ERR_ALIGN);
    check("align_err", n_err - b_err, 1);
    check("align_cnt", byte_cnt, 1);

    // over-long data packet
    snap();
    send_sync();
    send_byte(8'hC3);
    for (int i = 0; i < 1026; i++) send_byte(8'(i));
    settle();
    check("len_no_err_1026", n_err - b_err, 0);
    check("len_cnt_1026", byte_cnt, 1026);
    send_byte(8'h5A);
    settle();
    check("len_err", n_err - b_err, 1);
    check("len_code", err_code, ERR_LEN);
    check("len_cnt_1027", byte_cnt, 1027);
    check("len_valids", n_valid - b_valid, 1026);
    send_eop();

    // SYNC KJKJKKKK
    snap();
    line_bit(1'b0); line_bit(1'b1); line_bit(1'b0); line_bit(1'b1);
    line_bit(1'b0); line_bit(1'b0); line_bit(1'b0); line_bit(1'b0);
    send_eop();
    check("sync_code", err_code, ERR_SYNC);
    check("sync_err", n_err - b_err, 1);
    check("sync_pidv", n_pidv - b_pidv, 0);

    // reset pulse in the middle of a data packet
    snap();
    send_sync();
    send_byte(8'hC3);
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_dbit(1'b0);
    settle();
    check("mid_active", active, 1);
    check("mid_cnt", byte_cnt, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rst_active", active, 0);
    check("mid_rst_cnt", byte_cnt, 0);
    check("mid_rst_pid", pid, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_code", err_code, ERR_NONE);
    send_eop();
    check("mid_rst_done", n_done - b_done, 0);
    check("mid_rst_err", n_err - b_err, 0);
    tx_q = '{8'h2D, 8'h00, 8'h10};
    snap(); send_pkt(0);
    check("post_rst_pid", pid, 4'hD);
    check_bytes("post_rst_data");
    check("post_rst_done", n_done - b_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
